// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        MEASURE,
        HOLD,
        RUN,
        FAULT
    } state_e;

    // Inclusive tolerance band around the expected count; the lower bound floors at zero.
    function automatic logic in_tol(input int unsigned cnt,
                                    input int unsigned exp_cnt,
                                    input int unsigned tol);
        int unsigned lo;
        lo = (exp_cnt > tol) ? (exp_cnt - tol) : 32'd0;
        return (cnt >= lo) && (cnt <= (exp_cnt + tol));
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, synchronous active-low clear.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies a PLL by lock and measured frequency before releasing a downstream reset.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned WINDOW       = 1024,
    parameter int unsigned EXP_CNT      = 200,
    parameter int unsigned TOL          = 4,
    parameter int unsigned GOOD_WINDOWS = 2,
    parameter int unsigned RST_HOLD     = 16,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock_in,
    input  logic             rst_n_in,
    input  logic             pll_lock_in,
    input  logic             meas_tgl_in,
    input  logic             clear_fault_in,
    output logic             rst_n_out,
    output logic             freq_ok_out,
    output logic             fault_out,
    output logic [CNT_W-1:0] last_cnt_out,
    output logic [1:0]       retry_cnt_out
);

    localparam int unsigned WIN_W  = $clog2(WINDOW);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam int unsigned GOOD_W = $clog2(GOOD_WINDOWS + 1);

    state_e            state, state_next;
    logic [GOOD_W-1:0] good, good_next;
    logic [HOLD_W-1:0] hold, hold_next;
    logic [1:0]        retry_next, retry_inc;
    logic              freq_ok_next;

    logic [1:0]       sync_q;
    logic             lock_s, tgl_s, tgl_d, tgl_edge;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt, cnt_total;
    logic             measuring, win_end, win_in_tol;

    sync_2ff #(.WIDTH(2)) u_sync (
        .clk   (clock_in),
        .rst_n (rst_n_in),
        .d     ({meas_tgl_in, pll_lock_in}),
        .q     (sync_q)
    );

    assign lock_s   = sync_q[0];
    assign tgl_s    = sync_q[1];
    assign tgl_edge = tgl_s ^ tgl_d;

    always_ff @(posedge clock_in) begin
        if (!rst_n_in) tgl_d <= 1'b0;
        else           tgl_d <= tgl_s;
    end

    // A lost lock suppresses the window so lock loss wins over a coincident window end.
    assign measuring  = ((state == MEASURE) || (state == HOLD) || (state == RUN)) && lock_s;
    assign cnt_total  = (tgl_edge && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign win_end    = measuring && (win_cnt == WIN_W'(WINDOW - 1));
    assign win_in_tol = in_tol(32'(cnt_total), EXP_CNT, TOL);
    assign retry_inc  = (retry_cnt_out < 2'(MAX_RETRY)) ? retry_cnt_out + 2'd1 : retry_cnt_out;

    // Window and transition counters
    always_ff @(posedge clock_in) begin
        if (!rst_n_in) begin
            win_cnt      <= '0;
            edge_cnt     <= '0;
            last_cnt_out <= '0;
        end else if (!measuring) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (win_end) begin
            win_cnt      <= '0;
            edge_cnt     <= '0;
            last_cnt_out <= cnt_total;
        end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            edge_cnt <= cnt_total;
        end
    end

    always_ff @(posedge clock_in) begin
        if (!rst_n_in) begin
            state         <= WAIT_LOCK;
            good          <= '0;
            hold          <= '0;
            retry_cnt_out <= '0;
            freq_ok_out   <= 1'b0;
            rst_n_out     <= 1'b0;
            fault_out     <= 1'b0;
        end else begin
            state         <= state_next;
            good          <= good_next;
            hold          <= hold_next;
            retry_cnt_out <= retry_next;
            freq_ok_out   <= freq_ok_next;
            rst_n_out     <= (state == RUN) && (state_next == RUN);
            fault_out     <= (state_next == FAULT);
        end
    end

    always_comb begin
        state_next   = state;
        good_next    = good;
        hold_next    = hold;
        retry_next   = retry_cnt_out;
        freq_ok_next = freq_ok_out;

        if ((state != FAULT) && !lock_s) begin
            state_next   = WAIT_LOCK;
            good_next    = '0;
            freq_ok_next = 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    freq_ok_next = 1'b0;
                    state_next   = MEASURE;
                    good_next    = '0;
                end
                MEASURE: begin
                    if (win_end) begin
                        freq_ok_next = win_in_tol;
                        if (win_in_tol) begin
                            good_next = good + GOOD_W'(1);
                            if (good_next == GOOD_W'(GOOD_WINDOWS)) begin
                                state_next = HOLD;
                                hold_next  = '0;
                            end
                        end else begin
                            good_next  = '0;
                            retry_next = retry_inc;
                            if (retry_inc == 2'(MAX_RETRY)) state_next = FAULT;
                        end
                    end
                end
                HOLD: begin
                    if (win_end) freq_ok_next = win_in_tol;
                    if (hold == HOLD_W'(RST_HOLD - 1)) state_next = RUN;
                    else                               hold_next  = hold + HOLD_W'(1);
                end
                RUN: begin
                    if (win_end) begin
                        freq_ok_next = win_in_tol;
                        if (!win_in_tol) begin
                            state_next   = WAIT_LOCK;
                            good_next    = '0;
                            retry_next   = retry_inc;
                            freq_ok_next = 1'b0;
                        end
                    end
                end
                FAULT: begin
                    if (clear_fault_in) begin
                        state_next   = WAIT_LOCK;
                        retry_next   = '0;
                        freq_ok_next = 1'b0;
                    end
                end
                default: state_next = WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor; toggle bursts are placed mid-window relative to MEASURE entry.
module tb_pll_lock_supervisor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pll_lock;
    logic        meas_tgl;
    logic        clear_fault;
    logic        dut_rst_n;
    logic        freq_ok;
    logic        fault;
    logic [15:0] last_cnt;
    logic [1:0]  retry_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor dut (
        .clock_in       (clk),
        .rst_n_in       (rst_n),
        .pll_lock_in    (pll_lock),
        .meas_tgl_in    (meas_tgl),
        .clear_fault_in (clear_fault),
        .rst_n_out      (dut_rst_n),
        .freq_ok_out    (freq_ok),
        .fault_out      (fault),
        .last_cnt_out   (last_cnt),
        .retry_cnt_out  (retry_cnt)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs window cycles start..1023: n transitions every 4 cycles from offset 100,
    // an optional extra transition and an optional one-cycle lock drop.
    task automatic run_partial(input int start, input int n, input int extra_at, input int drop_at);
        for (int c = start; c < 1024; c++) begin
            if (c >= 100 && c < 100 + 4 * n && ((c - 100) % 4) == 0) meas_tgl = ~meas_tgl;
            if (c == extra_at) meas_tgl = ~meas_tgl;
            if (c == drop_at) pll_lock = 1'b0;
            if (c == drop_at + 1) pll_lock = 1'b1;
            step(1);
        end
    endtask

    task automatic run_window(input int n);
        run_partial(0, n, -10, -10);
    endtask

    task automatic pulse_clear();
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rst_n"},   32'(dut_rst_n), 32'd0);
        chk({tag, "_freq_ok"}, 32'(freq_ok),   32'd0);
        chk({tag, "_fault"},   32'(fault),     32'd0);
        chk({tag, "_last"},    32'(last_cnt),  32'd0);
        chk({tag, "_retry"},   32'(retry_cnt), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        pll_lock    = 1'b0;
        meas_tgl    = 1'b0;
        clear_fault = 1'b0;
        step(4);
        chk_reset_outputs("por");

        rst_n = 1'b1;
        step(2);

        // Lock, two windows of 200, then RST_HOLD before release
        pll_lock = 1'b1;
        step(3);
        run_window(200);
        chk("w1_last", 32'(last_cnt), 32'd200);
        chk("w1_freq_ok", 32'(freq_ok), 32'd1);
        chk("w1_rst_n", 32'(dut_rst_n), 32'd0);
        run_window(200);
        step(16);
        chk("hold_end_rst_n", 32'(dut_rst_n), 32'd0);
        step(1);
        chk("release_rst_n", 32'(dut_rst_n), 32'd1);
        chk("release_retry", 32'(retry_cnt), 32'd0);
        run_partial(17, 200, -10, -10);
        chk("run_rst_n", 32'(dut_rst_n), 32'd1);
        chk("run_last", 32'(last_cnt), 32'd200);

        // One-cycle lock drop in RUN
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(2);
        chk("drop_rst_n", 32'(dut_rst_n), 32'd0);
        chk("drop_freq_ok", 32'(freq_ok), 32'd0);
        chk("drop_retry", 32'(retry_cnt), 32'd0);
        step(1);

        // Requalify at the tolerance edges 196 and 204
        run_window(196);
        chk("w196_last", 32'(last_cnt), 32'd196);
        chk("w196_freq_ok", 32'(freq_ok), 32'd1);
        run_window(204);
        chk("w204_last", 32'(last_cnt), 32'd204);
        step(17);
        chk("requal_rst_n", 32'(dut_rst_n), 32'd1);

        // Lock drop landing on the terminal cycle of an out-of-tolerance window
        run_partial(17, 195, -10, 1021);
        chk("coinc_rst_n", 32'(dut_rst_n), 32'd0);
        chk("coinc_retry", 32'(retry_cnt), 32'd0);
        chk("coinc_freq_ok", 32'(freq_ok), 32'd0);
        step(1);

        // Just outside tolerance: 195 and 205
        run_window(195);
        chk("w195_retry", 32'(retry_cnt), 32'd1);
        chk("w195_freq_ok", 32'(freq_ok), 32'd0);
        chk("w195_last", 32'(last_cnt), 32'd195);
        run_window(205);
        chk("w205_retry", 32'(retry_cnt), 32'd2);
        chk("w205_last", 32'(last_cnt), 32'd205);
        chk("w205_rst_n", 32'(dut_rst_n), 32'd0);
        pulse_clear();
        chk("ign_clear_retry", 32'(retry_cnt), 32'd2);
        chk("ign_clear_fault", 32'(fault), 32'd0);
        run_partial(1, 190, -10, -10);
        chk("fault1_fault", 32'(fault), 32'd1);
        chk("fault1_retry", 32'(retry_cnt), 32'd3);
        chk("fault1_last", 32'(last_cnt), 32'd190);
        step(10);
        chk("fault1_sticky", 32'(fault), 32'd1);
        chk("fault1_rst_n", 32'(dut_rst_n), 32'd0);
        pulse_clear();
        chk("clear1_fault", 32'(fault), 32'd0);
        chk("clear1_retry", 32'(retry_cnt), 32'd0);
        step(1);

        // Three windows at 190 from a clean retry count
        run_window(190);
        chk("r190a_retry", 32'(retry_cnt), 32'd1);
        run_window(190);
        chk("r190b_retry", 32'(retry_cnt), 32'd2);
        chk("r190b_fault", 32'(fault), 32'd0);
        run_window(190);
        chk("r190c_fault", 32'(fault), 32'd1);
        chk("r190c_retry", 32'(retry_cnt), 32'd3);
        chk("r190c_rst_n", 32'(dut_rst_n), 32'd0);
        pulse_clear();
        chk("clear2_retry", 32'(retry_cnt), 32'd0);
        chk("clear2_fault", 32'(fault), 32'd0);
        step(1);

        // Transition on the terminal window cycle belongs to that window
        run_partial(0, 200, 1021, -10);
        chk("term_last", 32'(last_cnt), 32'd201);
        chk("term_freq_ok", 32'(freq_ok), 32'd1);
        run_window(200);
        chk("term2_last", 32'(last_cnt), 32'd200);

        // Reset mid-HOLD
        step(5);
        rst_n = 1'b0;
        step(1);
        chk_reset_outputs("hold_rst");
        rst_n = 1'b1;
        step(3);

        // Requalify, then reset mid-RUN
        run_window(200);
        run_window(200);
        step(17);
        chk("final_release", 32'(dut_rst_n), 32'd1);
        step(50);
        rst_n = 1'b0;
        step(1);
        chk_reset_outputs("run_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
